// File: rtl/track_move_if.sv
//==============================================================================
// Module      : track_move_if
// Description : Move-command handshake between a host and track_move_ctrl.
//               The master presents a target position; the slave reports
//               whether the command is taken in the current cycle.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface track_move_if;
    logic       cmd_valid;
    logic [7:0] cmd_pos;
    logic       cmd_ready;

    modport master (output cmd_valid, output cmd_pos, input  cmd_ready);
    modport slave  (input  cmd_valid, input  cmd_pos, output cmd_ready);
endinterface

`default_nettype wire

// File: rtl/track_move_ctrl.sv
//==============================================================================
// Module      : track_move_ctrl
// Description : Station-positioning controller for a stepper-driven track.
//               Homes against a limit switch, steps forward/backward to a
//               commanded station, settles, and reports done/err pulses.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module track_move_ctrl #(
    parameter int STEP_TICKS     = 1000000,
    parameter int SETTLE_TICKS   = 250000,
    parameter int MAX_POS        = 200,
    parameter int HOME_MAX_STEPS = 255
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    track_move_if.slave     cmd_if,
    input  wire logic       home_req,
    input  wire logic       limit_home_i,
    input  wire logic       abort,
    output logic            move_o,
    output logic            back_o,
    output logic [7:0]      cur_pos,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic            homed
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_HOMING    = 3'd1,
        S_MOVE_FWD  = 3'd2,
        S_MOVE_BACK = 3'd3,
        S_SETTLE    = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    // One counter serves both step timing and settle timing.
    localparam int TICK_MAX = (STEP_TICKS > SETTLE_TICKS) ? STEP_TICKS : SETTLE_TICKS;
    localparam int TICK_W   = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
    localparam int HOME_W   = (HOME_MAX_STEPS > 1) ? $clog2(HOME_MAX_STEPS) : 1;

    localparam logic [TICK_W-1:0] STEP_LAST   = TICK_W'(STEP_TICKS - 1);
    localparam logic [TICK_W-1:0] SETTLE_LAST = TICK_W'(SETTLE_TICKS - 1);
    localparam logic [HOME_W-1:0] HOME_LAST   = HOME_W'(HOME_MAX_STEPS - 1);
    localparam logic [7:0]        MAX_POS_B   = 8'(MAX_POS);

    state_t              state_q, state_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [HOME_W-1:0]   home_cnt_q, home_cnt_d;
    logic [7:0]          pos_q, pos_d;
    logic [7:0]          target_q, target_d;
    logic                homed_q, homed_d;
    logic                err_q, err_d;
    logic                done_q, move_q, back_q, busy_q;
    logic                lim_meta_q, lim_s_q;

    logic                step_last;
    logic [TICK_W-1:0]   tick_next;
    logic [7:0]          pos_inc, pos_dec;

    // The switch is asynchronous to clk, so it is re-timed before the FSM sees it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lim_meta_q <= 1'b0;
            lim_s_q    <= 1'b0;
        end else begin
            lim_meta_q <= limit_home_i;
            lim_s_q    <= lim_meta_q;
        end
    end

    // Commands are only taken when idle; a homing request in the same cycle wins.
    assign cmd_if.cmd_ready = (state_q == S_IDLE) && !home_req && !abort;

    // Next-state and datapath decisions; abort overrides everything at the end.
    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        home_cnt_d = home_cnt_q;
        pos_d      = pos_q;
        target_d   = target_q;
        homed_d    = homed_q;
        err_d      = 1'b0;

        step_last = (tick_q == STEP_LAST);
        tick_next = step_last ? '0 : tick_q + 1'b1;
        pos_inc   = (pos_q >= MAX_POS_B) ? pos_q : pos_q + 8'd1;
        pos_dec   = (pos_q == 8'd0) ? pos_q : pos_q - 8'd1;

        case (state_q)
            S_IDLE: begin
                tick_d = '0;
                if (home_req && !abort) begin
                    state_d    = S_HOMING;
                    home_cnt_d = '0;
                end else if (cmd_if.cmd_ready && cmd_if.cmd_valid) begin
                    if (!homed_q || (cmd_if.cmd_pos > MAX_POS_B)) begin
                        err_d = 1'b1;
                    end else begin
                        target_d = cmd_if.cmd_pos;
                        if (cmd_if.cmd_pos > pos_q)      state_d = S_MOVE_FWD;
                        else if (cmd_if.cmd_pos < pos_q) state_d = S_MOVE_BACK;
                        else                             state_d = S_DONE;
                    end
                end
            end
            S_HOMING: begin
                if (lim_s_q) begin
                    pos_d   = 8'd0;
                    homed_d = 1'b1;
                    state_d = S_SETTLE;
                end else begin
                    tick_d = tick_next;
                    if (step_last) begin
                        if (home_cnt_q == HOME_LAST) begin
                            err_d   = 1'b1;
                            homed_d = 1'b0;
                            state_d = S_IDLE;
                        end else begin
                            home_cnt_d = home_cnt_q + 1'b1;
                        end
                    end
                end
            end
            S_MOVE_FWD: begin
                tick_d = tick_next;
                if (step_last) begin
                    pos_d = pos_inc;
                    if (pos_inc == target_q) state_d = S_SETTLE;
                end
            end
            S_MOVE_BACK: begin
                if (lim_s_q) begin
                    // Hitting home re-references the position regardless of target.
                    pos_d   = 8'd0;
                    err_d   = (target_q != 8'd0);
                    state_d = S_SETTLE;
                end else begin
                    tick_d = tick_next;
                    if (step_last) begin
                        pos_d = pos_dec;
                        if (pos_dec == target_q) state_d = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                if (tick_q == SETTLE_LAST) state_d = S_DONE;
                else                       tick_d  = tick_q + 1'b1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (abort) begin
            state_d    = S_IDLE;
            err_d      = 1'b0;
            pos_d      = pos_q;
            homed_d    = homed_q;
            target_d   = target_q;
            home_cnt_d = home_cnt_q;
        end

        // Every state starts its timing from zero.
        if (state_d != state_q) tick_d = '0;
    end

    // Controller state and registered outputs derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            tick_q     <= '0;
            home_cnt_q <= '0;
            pos_q      <= 8'd0;
            target_q   <= 8'd0;
            homed_q    <= 1'b0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            move_q     <= 1'b0;
            back_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            home_cnt_q <= home_cnt_d;
            pos_q      <= pos_d;
            target_q   <= target_d;
            homed_q    <= homed_d;
            err_q      <= err_d;
            done_q     <= (state_d == S_DONE);
            move_q     <= (state_d == S_HOMING) || (state_d == S_MOVE_FWD) ||
                          (state_d == S_MOVE_BACK);
            back_q     <= (state_d == S_HOMING) || (state_d == S_MOVE_BACK);
            busy_q     <= (state_d != S_IDLE);
        end
    end

    assign move_o  = move_q;
    assign back_o  = back_q;
    assign cur_pos = pos_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign homed   = homed_q;

endmodule

`default_nettype wire

// File: tb/tb_track_move_ctrl.sv
//==============================================================================
// Module      : tb_track_move_ctrl
// Description : Self-checking bench for track_move_ctrl: directed scenarios
//               with literal expectations, then randomized traffic compared
//               every cycle against a behavioural model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_track_move_ctrl;

    localparam int STEP   = 4;
    localparam int SETTLE = 3;
    localparam int MAXP   = 200;
    localparam int HOMEN  = 8;

    localparam int M_IDLE = 0, M_HOME = 1, M_FWD = 2, M_BACK = 3, M_SETTLE = 4, M_DONE = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       home_req = 1'b0;
    logic       limit_home_i = 1'b0;
    logic       abort = 1'b0;
    logic       move_o, back_o, busy, done, err, homed;
    logic [7:0] cur_pos;

    track_move_if cmd_if();

    track_move_ctrl #(
        .STEP_TICKS(STEP), .SETTLE_TICKS(SETTLE), .MAX_POS(MAXP), .HOME_MAX_STEPS(HOMEN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmd_if(cmd_if), .home_req(home_req),
        .limit_home_i(limit_home_i), .abort(abort), .move_o(move_o), .back_o(back_o),
        .cur_pos(cur_pos), .busy(busy), .done(done), .err(err), .homed(homed)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int   m_mode = M_IDLE;
    int   m_elapsed = 0;      // cycles spent in the current mode
    int   m_pos = 0;
    int   m_target = 0;
    bit   m_homed = 0;
    bit   m_err = 0;
    bit   lim_pipe [2] = '{0, 0};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = M_IDLE; m_elapsed = 0; m_pos = 0; m_target = 0;
            m_homed = 0; m_err = 0; lim_pipe[0] = 0; lim_pipe[1] = 0;
        end else begin
            int nm;
            bit ls;
            ls = lim_pipe[1];
            nm = m_mode;
            m_err = 0;
            if (abort) begin
                nm = M_IDLE;
            end else begin
                case (m_mode)
                    M_IDLE: begin
                        if (home_req) nm = M_HOME;
                        else if (cmd_if.cmd_valid) begin
                            if (!m_homed || int'(cmd_if.cmd_pos) > MAXP) m_err = 1;
                            else begin
                                m_target = int'(cmd_if.cmd_pos);
                                nm = (m_target > m_pos) ? M_FWD :
                                     (m_target < m_pos) ? M_BACK : M_DONE;
                            end
                        end
                    end
                    M_HOME: begin
                        if (ls) begin m_pos = 0; m_homed = 1; nm = M_SETTLE; end
                        else if (m_elapsed == HOMEN * STEP - 1) begin
                            m_err = 1; m_homed = 0; nm = M_IDLE;
                        end
                    end
                    M_FWD: begin
                        if (m_elapsed % STEP == STEP - 1) begin
                            if (m_pos < MAXP) m_pos++;
                            if (m_pos == m_target) nm = M_SETTLE;
                        end
                    end
                    M_BACK: begin
                        if (ls) begin
                            m_err = (m_target != 0); m_pos = 0; nm = M_SETTLE;
                        end else if (m_elapsed % STEP == STEP - 1) begin
                            if (m_pos > 0) m_pos--;
                            if (m_pos == m_target) nm = M_SETTLE;
                        end
                    end
                    M_SETTLE: if (m_elapsed == SETTLE - 1) nm = M_DONE;
                    default:  nm = M_IDLE;
                endcase
            end
            m_elapsed = (nm != m_mode) ? 0 : m_elapsed + 1;
            m_mode = nm;
            lim_pipe[1] = lim_pipe[0];
            lim_pipe[0] = limit_home_i;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("move_o",    move_o,  (m_mode == M_HOME || m_mode == M_FWD || m_mode == M_BACK));
            check("back_o",    back_o,  (m_mode == M_HOME || m_mode == M_BACK));
            check("busy",      busy,    (m_mode != M_IDLE));
            check("done",      done,    (m_mode == M_DONE));
            check("err",       err,     m_err);
            check("homed",     homed,   m_homed);
            check("cur_pos",   cur_pos, m_pos);
            check("cmd_ready", cmd_if.cmd_ready, (m_mode == M_IDLE && !home_req && !abort));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_cmd(input int p);
        @(posedge clk); #1;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_pos   = 8'(p);
        @(posedge clk); #1;
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic pulse_home();
        @(posedge clk); #1 home_req = 1'b1;
        @(posedge clk); #1 home_req = 1'b0;
    endtask

    // Wait for done (or err) within a cycle budget, counting motor cycles.
    task automatic wait_evt(input string name, input bit want_err, input int budget,
                            output int mv, output int bk);
        bit seen;
        seen = 0; mv = 0; bk = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (move_o) mv++;
            if (back_o) bk++;
            if (want_err ? err : done) seen = 1;
        end
        check(name, seen, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int mv, bk;
        bit got;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_pos   = 8'd0;
        #2 rst_n = 1'b0;
        chk_en = 1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_cur_pos", cur_pos, 0);
        check("rst_homed", homed, 0);
        check("rst_ready", cmd_if.cmd_ready, 1);

        // Command before homing is rejected.
        send_cmd(5);
        @(negedge clk);
        check("unhomed_err", err, 1);
        check("unhomed_move", move_o, 0);

        // Homing with the switch closing after three steps.
        pulse_home();
        repeat (12) @(posedge clk);
        #1 limit_home_i = 1'b1;
        wait_evt("home_done", 0, 50, mv, bk);
        check("home_pos", cur_pos, 0);
        check("home_homed", homed, 1);
        limit_home_i = 1'b0;
        repeat (3) @(posedge clk);

        // Forward to 3, then back to 1.
        send_cmd(3);
        wait_evt("fwd_done", 0, 60, mv, bk);
        check("fwd_cycles", mv, 12);
        check("fwd_back_cycles", bk, 0);
        check("fwd_pos", cur_pos, 3);
        send_cmd(1);
        wait_evt("back_done", 0, 60, mv, bk);
        check("back_cycles", bk, 8);
        check("back_pos", cur_pos, 1);

        // Out-of-range and same-position commands.
        send_cmd(201);
        @(negedge clk);
        check("range_err", err, 1);
        check("range_pos", cur_pos, 1);
        send_cmd(1);
        @(negedge clk);
        check("same_done", done, 1);
        check("same_move", move_o, 0);

        // Abort while moving forward at position 2.
        send_cmd(5);
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (cur_pos == 8'd2) got = 1;
        end
        check("reach_pos2", got, 1);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        check("abort_move", move_o, 0);
        check("abort_busy", busy, 0);
        check("abort_pos", cur_pos, 2);

        // Reset in the middle of a move.
        send_cmd(6);
        repeat (3) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("rstmid_move", move_o, 0);
        check("rstmid_back", back_o, 0);
        check("rstmid_homed", homed, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("rstmid_ready", cmd_if.cmd_ready, 1);

        // Homing timeout with no switch.
        pulse_home();
        wait_evt("home_timeout", 1, 100, mv, bk);
        check("timeout_cycles", mv, 32);
        check("timeout_homed", homed, 0);
        check("timeout_busy", busy, 0);

        // Re-home, then randomized traffic against the model.
        pulse_home();
        repeat (5) @(posedge clk);
        #1 limit_home_i = 1'b1;
        wait_evt("rehome_done", 0, 50, mv, bk);
        @(posedge clk); #1 limit_home_i = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            cmd_if.cmd_valid = ($urandom_range(0, 3) == 0);
            cmd_if.cmd_pos   = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(190, 255))
                                                           : 8'($urandom_range(0, 20));
            home_req = ($urandom_range(0, 199) == 0);
            abort    = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 49) == 0) limit_home_i = ~limit_home_i;
        end
        @(posedge clk); #1;
        cmd_if.cmd_valid = 1'b0; home_req = 1'b0; abort = 1'b0;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/track_move_ctrl.md
TRACK_MOVE_CTRL -- requirements
Module: track_move_ctrl

Interface
REQ-001 Parameter STEP_TICKS, default 1000000, SHALL be the clk cycles per motor step (one driver step period at 50 MHz).
REQ-002 Parameter SETTLE_TICKS, default 250000, SHALL be the clk cycles with motor stopped after a move before done.
REQ-003 Parameter MAX_POS, default 200, SHALL be the highest legal station position in steps.
REQ-004 Parameter HOME_MAX_STEPS, default 255, SHALL be the step limit for homing before timeout.
REQ-005 Port clk, input, 1, SHALL be the single system clock (50 MHz).
REQ-006 Port rst_n, input, 1, SHALL be the asynchronous active-low reset.
REQ-007 Port cmd_valid, input, 1, SHALL flag a move request.
REQ-008 Port cmd_pos, input, 8, SHALL be the target position in steps.
REQ-009 Port cmd_ready, output, 1, SHALL flag that a command is accepted this cycle.
REQ-010 Port home_req, input, 1, SHALL request homing.
REQ-011 Port limit_home_i, input, 1, SHALL be the asynchronous active-high home limit switch.
REQ-012 Port abort, input, 1, SHALL be a synchronous stop request.
REQ-013 Port move_o, input-to-driver enable, output, 1, SHALL drive the track driver move_i.
REQ-014 Port back_o, output, 1, SHALL drive the track driver back_i (1 = toward home).
REQ-015 Port cur_pos, output, 8, SHALL be the tracked position.
REQ-016 Ports busy, done, err, homed: each output, 1; busy = not IDLE, done/err = one-cycle pulses, homed = position valid.

Function
REQ-017 States SHALL be IDLE, HOMING, MOVE_FWD, MOVE_BACK, SETTLE, DONE.
REQ-018 limit_home_i SHALL pass a 2-flop synchronizer before use (lim_s); 2-cycle latency.
REQ-019 cmd_ready SHALL equal (state==IDLE && !home_req && !abort); home_req wins over cmd_valid in the same cycle.
REQ-020 IDLE + home_req SHALL enter HOMING next cycle; home_req outside IDLE SHALL be ignored.
REQ-021 An accepted command with homed=0 or cmd_pos>MAX_POS SHALL pulse err next cycle, remain IDLE, and change nothing else.
REQ-022 An accepted legal command SHALL go to MOVE_FWD if cmd_pos>cur_pos, MOVE_BACK if less, DONE if equal; the target is latched on acceptance.
REQ-023 move_o SHALL be 1 only in HOMING/MOVE_FWD/MOVE_BACK; back_o SHALL be 1 only in HOMING/MOVE_BACK, 0 otherwise.
REQ-024 A tick counter SHALL run 0..STEP_TICKS-1 in move states, clear on state entry, and wrap at terminal count.
REQ-025 At terminal count cur_pos SHALL increment (MOVE_FWD) or decrement (MOVE_BACK); when the new value equals target, next state is SETTLE.
REQ-026 In MOVE_BACK, lim_s=1 SHALL force cur_pos=0 and SETTLE; err pulses if target!=0.
REQ-027 In HOMING, lim_s=1 SHALL set cur_pos=0, homed=1, then SETTLE; after HOME_MAX_STEPS terminal counts without lim_s, err pulses, homed=0, state IDLE.
REQ-028 SETTLE SHALL last exactly SETTLE_TICKS cycles then enter DONE; DONE SHALL last one cycle with done=1, then IDLE.
REQ-029 abort SHALL take priority over limit and tick events in every state: next state IDLE, move_o=0, no done, cur_pos/homed retained.
REQ-030 cur_pos SHALL never wrap: no decrement below 0, no increment above MAX_POS.

Reset
REQ-031 rst_n low SHALL immediately set state IDLE, counters 0, synchronizer 0, cur_pos 0, homed 0, move_o/back_o/done/err/busy 0; cmd_ready is 1 on the first cycle after release.
REQ-032 Reset asserted mid-move SHALL stop the motor outputs combinationally with the async clear.

Verification (STEP_TICKS=4, SETTLE_TICKS=3, MAX_POS=200, HOME_MAX_STEPS=8)
REQ-033 cmd_valid, cmd_pos=5 before homing -> err pulse, state IDLE, move_o stays 0.
REQ-034 home_req, limit asserted after 3 steps -> move_o=back_o=1 until lim_s, cur_pos=0, homed=1, 3 SETTLE cycles, done pulse.
REQ-035 Homed, cmd_pos=3 -> move_o=1 back_o=0 for 12 cycles, cur_pos 1,2,3 every 4 cycles, SETTLE 3, done; then cmd_pos=1 -> back_o=1 for 8 cycles, cur_pos=1.
REQ-036 cmd_pos=201 -> err, no motion; cmd_pos=cur_pos -> done one cycle after acceptance, no motion.
REQ-037 abort during MOVE_FWD at cur_pos=2 -> next cycle IDLE, move_o=0, no done, cur_pos=2; rst_n low mid-move -> all outputs 0, homed=0.
REQ-038 home_req, limit never asserted -> err after 32 cycles of motion, homed=0, IDLE.
